// File: rtl/id_ex_pipe_if.sv
// ID/EX pipeline boundary bundle: decode-side offer, execute-side presentation
// and the valid/ready handshake on each side.
// slave  : the pipeline register itself.
// master : the surrounding decode/execute environment.
interface id_ex_pipe_if;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] instr_id;
    logic [31:0] instr_addr_id;
    logic [31:0] operand1_id;
    logic [31:0] operand2_id;
    logic        reg_wen_id;

    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] instr_id_ex;
    logic [31:0] instr_addr_ex;
    logic [31:0] operand1_ex;
    logic [31:0] operand2_ex;
    logic        reg_wen_ex;

    modport slave (
        input  id_valid, instr_id, instr_addr_id, operand1_id, operand2_id,
               reg_wen_id, ex_ready,
        output id_ready, ex_valid, instr_id_ex, instr_addr_ex, operand1_ex,
               operand2_ex, reg_wen_ex
    );

    modport master (
        output id_valid, instr_id, instr_addr_id, operand1_id, operand2_id,
               reg_wen_id, ex_ready,
        input  id_ready, ex_valid, instr_id_ex, instr_addr_ex, operand1_ex,
               operand2_ex, reg_wen_ex
    );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register for the RV32I core.
// Holds the decoded instruction, PC, operands and rd write enable and presents
// them to execute one cycle after acceptance. Empty slots present ADDI x0,x0,0
// with all other fields zero. flush turns every held entry into a bubble.
// Configuration macro ID_EX_SKID_EN:
//   defined   - main + skid entry, id_ready is a flop (no path from ex_ready)
//   undefined - single entry, id_ready = !ex_valid || ex_ready
module id_ex_pipe (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    id_ex_pipe_if.slave   bus
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
`ifdef ID_EX_SKID_EN
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
`else
        ST_ONE   = 2'd1
`endif
    } state_t;

    state_t      state_r;
    state_t      state_s;

    // main entry: drives the execute-side outputs directly
    logic        main_valid_r;
    logic [31:0] main_instr_r;
    logic [31:0] main_addr_r;
    logic [31:0] main_op1_r;
    logic [31:0] main_op2_r;
    logic        main_wen_r;

    logic        accept_s;
    logic        drain_s;
    logic        load_in_s;
    logic        clear_main_s;

`ifdef ID_EX_SKID_EN
    logic        ready_r;
    logic        fill_skid_s;
    logic        load_skid_s;
    logic [31:0] skid_instr_r;
    logic [31:0] skid_addr_r;
    logic [31:0] skid_op1_r;
    logic [31:0] skid_op2_r;
    logic        skid_wen_r;

    assign bus.id_ready = ready_r;
`else
    // without a skid slot an accept in ONE only works if main empties now
    assign bus.id_ready = !main_valid_r || bus.ex_ready;
`endif

    assign accept_s = bus.id_valid && bus.id_ready;
    assign drain_s  = main_valid_r && bus.ex_ready;

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Next occupancy and entry-movement controls; flush overrides every event
    always_comb begin
        state_s      = state_r;
        load_in_s    = 1'b0;
        clear_main_s = 1'b0;
`ifdef ID_EX_SKID_EN
        fill_skid_s  = 1'b0;
        load_skid_s  = 1'b0;
`endif
        if (flush) begin
            state_s      = ST_EMPTY;
            clear_main_s = 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        load_in_s = 1'b1;
                        state_s   = ST_ONE;
                    end else begin
                        state_s   = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && drain_s) begin
                        load_in_s = 1'b1;
                        state_s   = ST_ONE;
`ifdef ID_EX_SKID_EN
                    end else if (accept_s) begin
                        fill_skid_s = 1'b1;
                        state_s     = ST_TWO;
`endif
                    end else if (drain_s) begin
                        clear_main_s = 1'b1;
                        state_s      = ST_EMPTY;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
`ifdef ID_EX_SKID_EN
                ST_TWO: begin
                    if (drain_s) begin
                        load_skid_s = 1'b1;
                        state_s     = ST_ONE;
                    end else begin
                        state_s     = ST_TWO;
                    end
                end
`endif
                default: begin
                    state_s      = ST_EMPTY;
                    clear_main_s = 1'b1;
                end
            endcase
        end
    end

`ifdef ID_EX_SKID_EN
    // Registered ready: low exactly while both entries are occupied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r <= 1'b1;
        end else begin
            ready_r <= (state_s != ST_TWO);
        end
    end

    // Skid entry capture when main is stalled and a new instruction arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_instr_r <= 32'h0000_0000;
            skid_addr_r  <= 32'h0000_0000;
            skid_op1_r   <= 32'h0000_0000;
            skid_op2_r   <= 32'h0000_0000;
            skid_wen_r   <= 1'b0;
        end else if (fill_skid_s) begin
            skid_instr_r <= bus.instr_id;
            skid_addr_r  <= bus.instr_addr_id;
            skid_op1_r   <= bus.operand1_id;
            skid_op2_r   <= bus.operand2_id;
            skid_wen_r   <= bus.reg_wen_id;
        end
    end
`endif

    // Main entry: bubble when empty, else loaded from decode or from the skid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_r <= 1'b0;
            main_instr_r <= NOP_INSTR;
            main_addr_r  <= 32'h0000_0000;
            main_op1_r   <= 32'h0000_0000;
            main_op2_r   <= 32'h0000_0000;
            main_wen_r   <= 1'b0;
        end else if (clear_main_s) begin
            main_valid_r <= 1'b0;
            main_instr_r <= NOP_INSTR;
            main_addr_r  <= 32'h0000_0000;
            main_op1_r   <= 32'h0000_0000;
            main_op2_r   <= 32'h0000_0000;
            main_wen_r   <= 1'b0;
        end else if (load_in_s) begin
            main_valid_r <= 1'b1;
            main_instr_r <= bus.instr_id;
            main_addr_r  <= bus.instr_addr_id;
            main_op1_r   <= bus.operand1_id;
            main_op2_r   <= bus.operand2_id;
            main_wen_r   <= bus.reg_wen_id;
`ifdef ID_EX_SKID_EN
        end else if (load_skid_s) begin
            main_valid_r <= 1'b1;
            main_instr_r <= skid_instr_r;
            main_addr_r  <= skid_addr_r;
            main_op1_r   <= skid_op1_r;
            main_op2_r   <= skid_op2_r;
            main_wen_r   <= skid_wen_r;
`endif
        end
    end

    // main_wen_r is only ever set alongside main_valid_r, so it is already gated
    assign bus.ex_valid      = main_valid_r;
    assign bus.instr_id_ex   = main_instr_r;
    assign bus.instr_addr_ex = main_addr_r;
    assign bus.operand1_ex   = main_op1_r;
    assign bus.operand2_ex   = main_op2_r;
    assign bus.reg_wen_ex    = main_wen_r;

endmodule
